// File: rtl/coin_start_seq.sv
`default_nettype none
// ============================================================================
// Module   : coin_start_seq
// Purpose  : Registers player controls and converts debounced start presses
//            into coin / gap / start / cooldown pulse sequences for the core.
//            Define COIN_START_CREDIT_CNT_EN to add the saturating credits port.
// Revision : 1.0 - initial release
// ============================================================================
module coin_start_seq #(
    parameter int DEB_CYC   = 65536,
    parameter int COIN_CYC  = 1200000,
    parameter int GAP_CYC   = 2400000,
    parameter int START_CYC = 1200000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        hold,
    input  logic        cocktail,
    input  logic [15:0] joy0,
    input  logic [15:0] joy1,
    output logic [3:0]  p1_dir,
    output logic        p1_fire,
    output logic [3:0]  p2_dir,
    output logic        p2_fire,
    output logic        coin,
    output logic        start1,
    output logic        start2,
`ifdef COIN_START_CREDIT_CNT_EN
    output logic [7:0]  credits,
`endif
    output logic        busy
);

    localparam int c_MAX_CYC = (COIN_CYC > GAP_CYC) ?
                               ((COIN_CYC > START_CYC) ? COIN_CYC : START_CYC) :
                               ((GAP_CYC > START_CYC) ? GAP_CYC : START_CYC);
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam int c_DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_COIN_LAST  = c_CNT_W'(COIN_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_CYC - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST   = c_DEB_W'(DEB_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COIN  = 3'd1,
        S_GAP1  = 3'd2,
        S_START = 3'd3,
        S_COOL  = 3'd4
    } state_t;

    logic [15:0] w_joy_any;
    logic [15:0] w_joy_p2;
    logic        w_unused;

    assign w_joy_any = joy0 | joy1;
    assign w_joy_p2  = cocktail ? joy1 : w_joy_any;
    assign w_unused  = ^{joy0[15:7], joy1[15:7]};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_dir  <= '0;
            p1_fire <= 1'b0;
            p2_dir  <= '0;
            p2_fire <= 1'b0;
        end else if (hold) begin
            p1_dir  <= '0;
            p1_fire <= 1'b0;
            p2_dir  <= '0;
            p2_fire <= 1'b0;
        end else begin
            p1_dir  <= w_joy_any[3:0];
            p1_fire <= w_joy_any[4];
            p2_dir  <= w_joy_p2[3:0];
            p2_fire <= w_joy_p2[4];
        end
    end

    logic [1:0] w_raw;
    logic [1:0] w_deb_nxt;
    logic [1:0] r_deb;
    logic [1:0] r_deb_q;
    logic [1:0] w_rise;
    logic       w_req;

    assign w_raw = w_joy_any[6:5];

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [c_DEB_W-1:0] r_cnt;
        logic               w_diff;
        logic               w_done;

        assign w_diff       = w_raw[i] ^ r_deb[i];
        assign w_done       = w_diff && (r_cnt == c_DEB_LAST);
        assign w_deb_nxt[i] = w_done ? w_raw[i] : r_deb[i];

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
            end else if (!w_diff || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Edges that appear while hold is high are absorbed into r_deb_q so they
    // can never surface as a request once hold drops.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_deb   <= '0;
            r_deb_q <= '0;
        end else begin
            r_deb   <= w_deb_nxt;
            r_deb_q <= hold ? w_deb_nxt : r_deb;
        end
    end

    assign w_rise = r_deb & ~r_deb_q;
    assign w_req  = !hold && (w_rise != 2'b00);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_p2;
    logic               w_p2_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_p2_nxt    = r_p2;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_req) begin
                    w_state_nxt = S_COIN;
                    w_p2_nxt    = w_rise[1];
                end
            end
            S_COIN: begin
                if (r_cnt == c_COIN_LAST) begin
                    w_state_nxt = S_GAP1;
                    w_cnt_nxt   = '0;
                end
            end
            S_GAP1: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == c_START_LAST) begin
                    w_state_nxt = S_COOL;
                    w_cnt_nxt   = '0;
                end
            end
            S_COOL: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (hold) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    // Pulse outputs are decoded from the next state so they line up exactly
    // with the state they belong to.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_p2    <= 1'b0;
            coin    <= 1'b0;
            start1  <= 1'b0;
            start2  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_p2    <= w_p2_nxt;
            coin    <= (w_state_nxt == S_COIN);
            start1  <= (w_state_nxt == S_START) && !w_p2_nxt;
            start2  <= (w_state_nxt == S_START) && w_p2_nxt;
            busy    <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef COIN_START_CREDIT_CNT_EN
    logic [7:0] r_credits;
    logic       w_credit_inc;

    assign w_credit_inc = (r_state == S_COIN) && (r_cnt == c_COIN_LAST) && !hold;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_credits <= '0;
        end else if (w_credit_inc && (r_credits != 8'hFF)) begin
            r_credits <= r_credits + 8'd1;
        end
    end

    assign credits = r_credits;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coin_start_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_start_seq
// Purpose  : Self-checking bench for coin_start_seq (control table, timed
//            sequences, randomized traffic against a timeline reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_start_seq;

    localparam int DEB   = 4;
    localparam int COINC = 10;
    localparam int GAPC  = 5;
    localparam int STRC  = 8;
    localparam int TOTAL = COINC + GAPC + STRC + GAPC;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        hold = 1'b0;
    logic        cocktail = 1'b0;
    logic [15:0] joy0 = '0;
    logic [15:0] joy1 = '0;
    logic [3:0]  p1_dir;
    logic        p1_fire;
    logic [3:0]  p2_dir;
    logic        p2_fire;
    logic        coin;
    logic        start1;
    logic        start2;
    logic        busy;
`ifdef COIN_START_CREDIT_CNT_EN
    logic [7:0]  credits;
`endif

    coin_start_seq #(
        .DEB_CYC   (DEB),
        .COIN_CYC  (COINC),
        .GAP_CYC   (GAPC),
        .START_CYC (STRC)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .hold     (hold),
        .cocktail (cocktail),
        .joy0     (joy0),
        .joy1     (joy1),
        .p1_dir   (p1_dir),
        .p1_fire  (p1_fire),
        .p2_dir   (p2_dir),
        .p2_fire  (p2_fire),
        .coin     (coin),
        .start1   (start1),
        .start2   (start2),
`ifdef COIN_START_CREDIT_CNT_EN
        .credits  (credits),
`endif
        .busy     (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: debounce from a sample history window, sequence from
    // the age (edges since acceptance) on a fixed pulse timeline.
    logic [1:0] m_lvl;
    logic [1:0] m_hist[$];
    bit         m_pend, m_pend_p2, m_act, m_p2;
    int         m_age, m_cred;
    logic [3:0] m_p1d, m_p2d;
    logic       m_p1f, m_p2f;

    task automatic model_reset();
        m_lvl = '0; m_hist.delete();
        m_pend = 0; m_pend_p2 = 0; m_act = 0; m_p2 = 0;
        m_age = 0; m_cred = 0;
        m_p1d = '0; m_p2d = '0; m_p1f = 0; m_p2f = 0;
    endtask

    task automatic model_edge();
        logic [15:0] any, j2;
        logic [1:0]  raw, newlvl, rise;
        bit          all;
        any = joy0 | joy1;
        j2  = cocktail ? joy1 : any;
        raw = any[6:5];
        newlvl = m_lvl;
        m_hist.push_back(raw);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        for (int b = 0; b < 2; b++) begin
            if (m_hist.size() == DEB) begin
                all = 1;
                foreach (m_hist[k]) if (m_hist[k][b] == m_lvl[b]) all = 0;
                if (all) newlvl[b] = raw[b];
            end
        end
        rise = newlvl & ~m_lvl;
        if (hold) begin
            m_act = 0;
        end else if (m_act) begin
            m_age++;
            if (m_age == COINC && m_cred < 255) m_cred++;
            if (m_age == TOTAL) m_act = 0;
        end else if (m_pend) begin
            m_act = 1; m_age = 0; m_p2 = m_pend_p2;
        end
        m_pend    = !hold && (rise != 2'b00);
        m_pend_p2 = rise[1];
        m_lvl     = newlvl;
        m_p1d = hold ? 4'd0 : any[3:0];
        m_p1f = hold ? 1'b0 : any[4];
        m_p2d = hold ? 4'd0 : j2[3:0];
        m_p2f = hold ? 1'b0 : j2[4];
    endtask

    function automatic logic [13:0] outs();
        return {p1_dir, p1_fire, p2_dir, p2_fire, coin, start1, start2, busy};
    endfunction

    function automatic logic [13:0] m_outs();
        logic c, s;
        c = m_act && (m_age < COINC);
        s = m_act && (m_age >= COINC + GAPC) && (m_age < COINC + GAPC + STRC);
        return {m_p1d, m_p1f, m_p2d, m_p2f, c, s && !m_p2, s && m_p2, m_act};
    endfunction

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
        chk("cycle_outputs", 32'(outs()), 32'(m_outs()));
`ifdef COIN_START_CREDIT_CNT_EN
        chk("cycle_credits", 32'(credits), 32'(m_cred));
`endif
    endtask

    task automatic do_reset();
        reset_n = 1'b0; hold = 1'b0; cocktail = 1'b0; joy0 = '0; joy1 = '0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("reset_outputs", 32'(outs()), 32'd0);
`ifdef COIN_START_CREDIT_CNT_EN
        chk("reset_credits", 32'(credits), 32'd0);
`endif
        model_reset();
        reset_n = 1'b1;
    endtask

    logic [127:0] tr_coin, tr_s1, tr_s2, tr_busy;

    task automatic clr_trace();
        tr_coin = '0; tr_s1 = '0; tr_s2 = '0; tr_busy = '0;
    endtask

    task automatic rec(input int k);
        tr_coin[k] = coin; tr_s1[k] = start1; tr_s2[k] = start2; tr_busy[k] = busy;
    endtask

    function automatic int first_one(input logic [127:0] v);
        for (int i = 0; i < 128; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int last_one(input logic [127:0] v);
        for (int i = 127; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        logic        h;
        logic        ck;
        logic [15:0] j0;
        logic [15:0] j1;
        logic [3:0]  e_p1d;
        logic        e_p1f;
        logic [3:0]  e_p2d;
        logic        e_p2f;
    } ctl_vec_t;

    ctl_vec_t vecs[8];
    logic     sb0, sb1;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'h0008, 16'h0001, 4'b1001, 1'b0, 4'b0001, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h0008, 16'h0001, 4'b1001, 1'b0, 4'b1001, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 4'b0000, 1'b1, 4'b0000, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h0016, 4'b0110, 1'b1, 4'b0110, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 16'h0005, 16'h000A, 4'b1111, 1'b0, 4'b1111, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h001F, 16'h001F, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'hFF8F, 16'h0000, 4'b1111, 1'b0, 4'b0000, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 4'b0000, 1'b0};

        do_reset();
        repeat (5) step();
        chk("idle_after_reset", 32'(outs()), 32'd0);

        // Controls: one-cycle registered path, cocktail mux, hold forcing.
        for (int i = 0; i < 8; i++) begin
            hold = vecs[i].h; cocktail = vecs[i].ck; joy0 = vecs[i].j0; joy1 = vecs[i].j1;
            step();
            chk("ctl_vec", 32'({p1_dir, p1_fire, p2_dir, p2_fire}),
                32'({vecs[i].e_p1d, vecs[i].e_p1f, vecs[i].e_p2d, vecs[i].e_p2f}));
        end
        hold = 1'b0; cocktail = 1'b0; joy0 = '0; joy1 = '0;
        repeat (3) step();

        // Single 1P start held through the whole sequence.
        clr_trace();
        joy0 = 16'h0020;
        for (int k = 1; k <= 40; k++) begin step(); rec(k); end
        chk("s1_coin_first", 32'(first_one(tr_coin)), 32'd5);
        chk("s1_coin_width", 32'($countones(tr_coin)), 32'd10);
        chk("s1_start_first", 32'(first_one(tr_s1)), 32'd20);
        chk("s1_start_width", 32'($countones(tr_s1)), 32'd8);
        chk("s1_busy_last", 32'(last_one(tr_busy)), 32'd32);
        chk("s1_start2_quiet", 32'($countones(tr_s2)), 32'd0);
        joy0 = '0;
        repeat (8) step();

        // Three-cycle glitch on start2 must not start anything.
        clr_trace();
        for (int k = 1; k <= 30; k++) begin
            joy1 = (k <= 3) ? 16'h0040 : 16'h0000;
            step(); rec(k);
        end
        chk("glitch_busy", 32'($countones(tr_busy)), 32'd0);
        chk("glitch_coin", 32'($countones(tr_coin)), 32'd0);

        // Both starts rise together: 2P wins.
        clr_trace();
        joy0 = 16'h0020; joy1 = 16'h0040;
        for (int k = 1; k <= 40; k++) begin step(); rec(k); end
        chk("coll_start2_width", 32'($countones(tr_s2)), 32'd8);
        chk("coll_start2_first", 32'(first_one(tr_s2)), 32'd20);
        chk("coll_start1_quiet", 32'($countones(tr_s1)), 32'd0);
        joy0 = '0; joy1 = '0;
        repeat (8) step();

        // Second press lands during GAP1 and is discarded.
        clr_trace();
        for (int k = 1; k <= 60; k++) begin
            joy0 = ((k <= 6) || (k >= 13 && k <= 30)) ? 16'h0020 : 16'h0000;
            step(); rec(k);
        end
        chk("mid_coin_count", 32'($countones(tr_coin)), 32'd10);
        chk("mid_start1_count", 32'($countones(tr_s1)), 32'd8);
        chk("mid_busy_count", 32'($countones(tr_busy)), 32'd28);

        // hold during START aborts; releasing hold with the button held is quiet.
        clr_trace();
        joy0 = 16'h0020;
        for (int k = 1; k <= 60; k++) begin
            hold = (k >= 22 && k <= 24);
            step(); rec(k);
        end
        chk("hold_start1_count", 32'($countones(tr_s1)), 32'd2);
        chk("hold_busy_last", 32'(last_one(tr_busy)), 32'd21);
        chk("hold_coin_count", 32'($countones(tr_coin)), 32'd10);
        hold = 1'b0; joy0 = '0;
        repeat (8) step();

        // Randomized traffic, every cycle checked against the model.
        sb0 = 1'b0; sb1 = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) sb0 = ~sb0;
            if ($urandom_range(0, 7) == 0) sb1 = ~sb1;
            if (hold) begin
                if ($urandom_range(0, 4) == 0) hold = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                hold = 1'b1;
            end
            cocktail = 1'($urandom_range(0, 1));
            joy0 = 16'($urandom);
            joy1 = 16'($urandom);
            joy0[6:5] = {1'b0, sb0};
            joy1[6:5] = {sb1, 1'b0};
            step();
        end
        hold = 1'b0; cocktail = 1'b0; joy0 = '0; joy1 = '0;
        repeat (40) step();

`ifdef COIN_START_CREDIT_CNT_EN
        do_reset();
        repeat (3) step();
        for (int s = 0; s < 256; s++) begin
            joy0 = 16'h0020;
            repeat (40) step();
            joy0 = '0;
            repeat (8) step();
            if (s == 2) chk("credits_three", 32'(credits), 32'd3);
        end
        chk("credits_saturate", 32'(credits), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
